// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the execute stage (ALU ops, forward selects, branch funct3, multiply states)
package riscv_pkg;
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_W   = 2'b01;
   localparam logic [1:0] FWD_M   = 2'b10;
   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;
   function automatic logic [31:0] alu_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_ADD: alu_op = a + b;
         ALU_SUB: alu_op = a - b;
         ALU_AND: alu_op = a & b;
         ALU_OR:  alu_op = a | b;
         ALU_XOR: alu_op = a ^ b;
         ALU_SLT: alu_op = {31'd0, $signed(a) < $signed(b)};
         ALU_SLL: alu_op = a << b[4:0];
         default: alu_op = a >> b[4:0];
      endcase
   endfunction
endpackage

// File: rtl/execute_stage_if.sv
// execute_stage_if: E-stage inputs, fetch redirect, stall and registered M-stage outputs
interface execute_stage_if;
   logic        regwriteE, memwriteE, jumpE, branchE, alusrcE, mulE;
   logic [1:0]  resultsrcE;
   logic [2:0]  alucontrolE, funct3E;
   logic [4:0]  rdE;
   logic [31:0] rd1E, rd2E, pcE, pcplus4E, immextE;
   logic [1:0]  forwardaE, forwardbE;
   logic [31:0] resultW;
   logic        pcsrcE, stallE;
   logic [31:0] pctargetE;
   logic        regwriteM, memwriteM;
   logic [1:0]  resultsrcM;
   logic [2:0]  funct3M;
   logic [4:0]  rdM;
   logic [31:0] aluresultM, writedataM, pcplus4M;
   modport master (
      output regwriteE, memwriteE, jumpE, branchE, alusrcE, mulE, resultsrcE, alucontrolE, funct3E, rdE,
             rd1E, rd2E, pcE, pcplus4E, immextE, forwardaE, forwardbE, resultW,
      input  pcsrcE, stallE, pctargetE, regwriteM, memwriteM, resultsrcM, funct3M, rdM,
             aluresultM, writedataM, pcplus4M
   );
   modport slave (
      input  regwriteE, memwriteE, jumpE, branchE, alusrcE, mulE, resultsrcE, alucontrolE, funct3E, rdE,
             rd1E, rd2E, pcE, pcplus4E, immextE, forwardaE, forwardbE, resultW,
      output pcsrcE, stallE, pctargetE, regwriteM, memwriteM, resultsrcM, funct3M, rdM,
             aluresultM, writedataM, pcplus4M
   );
endinterface

// File: rtl/mul_iter.sv
// mul_iter: 32-step shift-add multiplier returning the low 32 product bits (IDLE/BUSY/DONE)
module mul_iter
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_start,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_product
);
   mul_state_t  r_state;
   logic [4:0]  r_cnt;
   logic [31:0] r_a, r_b, r_acc;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= MUL_IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
      end else begin
         case (r_state)
            MUL_IDLE: if (i_start) begin
               r_a     <= i_a;
               r_b     <= i_b;
               r_acc   <= '0;
               r_cnt   <= '0;
               r_state <= MUL_BUSY;
            end
            MUL_BUSY: begin
               if (r_b[0]) r_acc <= r_acc + r_a;
               r_a   <= r_a << 1;
               r_b   <= r_b >> 1;
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd31) r_state <= MUL_DONE;
            end
            default: r_state <= MUL_IDLE;
         endcase
      end
   end
   assign o_busy    = (r_state == MUL_BUSY);
   assign o_done    = (r_state == MUL_DONE);
   assign o_product = r_acc;
endmodule

// File: rtl/execute_stage.sv
// execute_stage: forwarding, ALU, branch resolve and E->M register; iterative multiply under EXECUTE_MUL_EN
module execute_stage
   import riscv_pkg::*;
(
   input logic            clk,
   input logic            reset_n,
   execute_stage_if.slave ex
);
   logic [31:0] w_srca, w_writedata, w_srcb, w_alu, w_product;
   logic        w_eq, w_lt, w_taken, w_stall, w_done;
   logic        r_regwriteM, r_memwriteM;
   logic [1:0]  r_resultsrcM;
   logic [2:0]  r_funct3M;
   logic [4:0]  r_rdM;
   logic [31:0] r_aluresultM, r_writedataM, r_pcplus4M;
   assign w_srca      = (ex.forwardaE == FWD_W) ? ex.resultW : (ex.forwardaE == FWD_M) ? r_aluresultM : ex.rd1E;
   assign w_writedata = (ex.forwardbE == FWD_W) ? ex.resultW : (ex.forwardbE == FWD_M) ? r_aluresultM : ex.rd2E;
   assign w_srcb      = ex.alusrcE ? ex.immextE : w_writedata;
   assign w_alu       = alu_op(ex.alucontrolE, w_srca, w_srcb);
   assign w_eq        = (w_srca == w_writedata);
   assign w_lt        = $signed(w_srca) < $signed(w_writedata);
   assign w_taken     = (ex.funct3E == BR_BEQ) ? w_eq :
                        (ex.funct3E == BR_BNE) ? ~w_eq :
                        (ex.funct3E == BR_BLT) ? w_lt :
                        (ex.funct3E == BR_BGE) ? ~w_lt : 1'b0;
   assign ex.pcsrcE    = ex.jumpE | (ex.branchE & w_taken);
   assign ex.pctargetE = ex.pcE + ex.immextE;
`ifdef EXECUTE_MUL_EN
   logic w_busy;
   mul_iter u_mul (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_start   (ex.mulE),
      .i_a       (w_srca),
      .i_b       (w_srcb),
      .o_busy    (w_busy),
      .o_done    (w_done),
      .o_product (w_product)
   );
   // stall covers the start cycle in IDLE plus all of BUSY; forced low while reset is held
   assign w_stall = reset_n & (w_busy | (ex.mulE & ~w_done));
`else
   assign w_stall   = 1'b0;
   assign w_done    = 1'b0;
   assign w_product = '0;
`endif
   assign ex.stallE = w_stall;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_regwriteM  <= 1'b0;
         r_memwriteM  <= 1'b0;
         r_resultsrcM <= '0;
         r_funct3M    <= '0;
         r_rdM        <= '0;
         r_aluresultM <= '0;
         r_writedataM <= '0;
         r_pcplus4M   <= '0;
      end else if (w_stall) begin
         r_regwriteM <= 1'b0;
         r_memwriteM <= 1'b0;
      end else begin
         r_regwriteM  <= ex.regwriteE;
         r_memwriteM  <= ex.memwriteE;
         r_resultsrcM <= ex.resultsrcE;
         r_funct3M    <= ex.funct3E;
         r_rdM        <= ex.rdE;
         r_aluresultM <= w_done ? w_product : w_alu;
         r_writedataM <= w_writedata;
         r_pcplus4M   <= ex.pcplus4E;
      end
   end
   assign ex.regwriteM  = r_regwriteM;
   assign ex.memwriteM  = r_memwriteM;
   assign ex.resultsrcM = r_resultsrcM;
   assign ex.funct3M    = r_funct3M;
   assign ex.rdM        = r_rdM;
   assign ex.aluresultM = r_aluresultM;
   assign ex.writedataM = r_writedataM;
   assign ex.pcplus4M   = r_pcplus4M;
endmodule
